alu_pipe: RTL and testbench

Parametrised, handshaked ALU for the datapath. Generalises the 2-bit-opcode combinational ALU to WIDTH-bit operands and a 3-bit opcode, adding XOR, shifts, status flags and an iterative shift-add multiplier. Operands enter through a valid/ready input port; results leave through a registered valid/ready output port, so upstream and downstream stages can stall independently.

---
 rtl/alu_pipe_if.sv | 27 ++
 rtl/alu_pipe.sv | 172 +++++++++++++++++
 tb/tb_alu_pipe.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_if.sv
// Operand/result port bundle for alu_pipe.
// Valid/ready: a transfer happens on a rising edge where valid && ready; the sender holds its payload stable while valid && !ready.
interface alu_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             flag_zero;
  logic             flag_carry;
  logic             flag_ovf;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, out, flag_zero, flag_carry, flag_ovf
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, out, flag_zero, flag_carry, flag_ovf
  );
endinterface

// File: rtl/alu_pipe.sv
// Handshaked WIDTH-bit ALU with registered result and flags.
// Define ALU_MUL_EN to build the iterative shift-add multiplier for op 7; otherwise op 7 reports unsupported.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       nreset,
  alu_pipe_if.slave  bus,
  output logic       dbg_state
);

  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_e;

  localparam int CW = $clog2(WIDTH);

  state_e           cur_state;
  logic             accept;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             alu_ovf;

  logic             load;
  logic [WIDTH-1:0] load_res;
  logic             load_carry;
  logic             load_ovf;

  logic [WIDTH-1:0] out_q, out_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;

  assign bus.in_ready = (cur_state == S_IDLE) && (!valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign dbg_state    = cur_state;

  // Single-cycle datapath; op 7 lands in default as the unsupported marker.
  always_comb begin
    sum       = {1'b0, bus.a} + {1'b0, bus.b};
    diff      = {1'b0, bus.a} - {1'b0, bus.b};
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (bus.op)
      3'd0: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
        alu_ovf   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      3'd1: begin
        alu_res   = diff[WIDTH-1:0];
        alu_carry = diff[WIDTH];
        alu_ovf   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      3'd2: alu_res = bus.a & bus.b;
      3'd3: alu_res = bus.a | bus.b;
      3'd4: alu_res = bus.a ^ bus.b;
      3'd5: alu_res = bus.a << bus.b;
      3'd6: alu_res = bus.a >> bus.b;
      default: alu_ovf = 1'b1;
    endcase
  end

`ifdef ALU_MUL_EN
  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic               mul_done;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  // One multiplier bit per cycle, LSB first; the last iteration loads the result directly.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    mul_done = 1'b0;
    if (state_q == S_IDLE) begin
      if (accept && (bus.op == 3'd7)) begin
        state_d  = S_MUL;
        cnt_d    = '0;
        acc_d    = '0;
        mcand_d  = {{WIDTH{1'b0}}, bus.a};
        mplier_d = bus.b;
      end
    end else begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == CW'(WIDTH - 1)) begin
        mul_done = 1'b1;
        state_d  = S_IDLE;
        cnt_d    = '0;
      end
    end
  end

  assign cur_state  = state_q;
  assign load       = (accept && (bus.op != 3'd7)) || mul_done;
  assign load_res   = mul_done ? acc_d[WIDTH-1:0] : alu_res;
  assign load_carry = mul_done ? (|acc_d[2*WIDTH-1:WIDTH]) : alu_carry;
  assign load_ovf   = mul_done ? 1'b0 : alu_ovf;
`else
  assign cur_state  = S_IDLE;
  assign load       = accept;
  assign load_res   = alu_res;
  assign load_carry = alu_carry;
  assign load_ovf   = alu_ovf;
`endif

  // A new load wins over a same-cycle consume so back-to-back results never bubble.
  always_comb begin
    out_d   = out_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;
    if (load) begin
      out_d   = load_res;
      zero_d  = (load_res == '0);
      carry_d = load_carry;
      ovf_d   = load_ovf;
      valid_d = 1'b1;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      out_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign bus.out        = out_q;
  assign bus.flag_zero  = zero_q;
  assign bus.flag_carry = carry_q;
  assign bus.flag_ovf   = ovf_q;
  assign bus.out_valid  = valid_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed cases from the plan plus randomized ops with random backpressure.
// Follows the ALU_MUL_EN build of the design.
module tb_alu_pipe;
  localparam int W  = 8;
  localparam int EW = W + 3;

  logic clk = 1'b0;
  logic nreset;
  logic dbg_state;

  alu_pipe_if #(.WIDTH(W)) bus ();

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  logic rand_bp = 1'b0;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [EW-1:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint m  = longint'(1) << W;
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint sa = (ua >= m / 2) ? ua - m : ua;
    longint sb = (ub >= m / 2) ? ub - m : ub;
    longint r  = 0;
    longint sr = 0;
    bit c = 1'b0;
    bit v = 1'b0;
    logic [W-1:0] ro;
    case (op)
      3'd0: begin
        r = ua + ub; c = (r >= m); r = r % m;
        sr = sa + sb; v = (sr >= m / 2) || (sr < -(m / 2));
      end
      3'd1: begin
        r = (ua - ub + m) % m; c = (ua < ub);
        sr = sa - sb; v = (sr >= m / 2) || (sr < -(m / 2));
      end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: r = (ub >= W) ? 0 : ((ua << ub) % m);
      3'd6: r = (ub >= W) ? 0 : (ua >> ub);
      default: begin
`ifdef ALU_MUL_EN
        r = ua * ub; c = (r >= m); r = r % m;
`else
        r = 0; v = 1'b1;
`endif
      end
    endcase
    ro = r[W-1:0];
    return {ro, (r == 0), c, v};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.a  = a;
    bus.b  = b;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 after %0d cycles, expected 1", n);
    end else begin
      exp_q.push_back(model(op, a, b));
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Counts cycles from the accepting edge until out_valid is seen.
  task automatic wait_valid(input string name, input int exp_lat);
    int k = 1;
    int busy = 0;
    @(negedge clk);
    while (!bus.out_valid && k < 100) begin
      if (bus.in_ready) busy++;
      k++;
      @(negedge clk);
    end
    check({name, "_latency"}, k, exp_lat);
    if (exp_lat > 1) check({name, "_in_ready_busy"}, busy, 0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_out_valid"}, bus.out_valid, 0);
    check({name, "_out"}, bus.out, 0);
    check({name, "_flags"}, {bus.flag_zero, bus.flag_carry, bus.flag_ovf}, 0);
    check({name, "_in_ready"}, bus.in_ready, 1);
    check({name, "_state"}, dbg_state, 0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] act;
    logic [EW-1:0] e;
    act = {bus.out, bus.flag_zero, bus.flag_carry, bus.flag_ovf};
    if (nreset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL result_unexpected: got 0x%0h, expected no result", act);
      end else begin
        e = exp_q.pop_front();
        check("result", act, e);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_bp) bus.out_ready = 1'($urandom_range(0, 1));
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [EW:0] snap;
    logic [2:0]  rop;
    logic [W-1:0] ra, rb;
    int n;

    bus.in_valid  = 1'b0;
    bus.op        = 3'd0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    nreset        = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    nreset = 1'b1;
    sync();

    issue(3'd0, 8'd200, 8'd100);
    wait_valid("add", 1);
    sync();

    issue(3'd1, 8'h80, 8'h01);
    issue(3'd1, 8'd5, 8'd5);
    issue(3'd4, 8'hF0, 8'h3C);
    issue(3'd5, 8'h81, 8'd1);
    issue(3'd6, 8'h81, 8'd9);
    issue(3'd5, 8'h01, 8'd8);
    issue(3'd6, 8'h80, 8'd7);
    issue(3'd0, 8'h7F, 8'h01);
    issue(3'd2, 8'hA5, 8'h0F);
    issue(3'd3, 8'hA0, 8'h05);

`ifdef ALU_MUL_EN
    issue(3'd7, 8'd13, 8'd11);
    wait_valid("mul", W + 1);
    sync();
    issue(3'd7, 8'd16, 8'd16);
    issue(3'd7, 8'd255, 8'd255);
`else
    issue(3'd7, 8'd3, 8'd3);
    wait_valid("op7", 1);
    sync();
`endif

    // backpressure: result 1 held, two more ops queue behind it
    bus.out_ready = 1'b0;
    issue(3'd0, 8'd10, 8'd20);
    fork
      begin
        issue(3'd0, 8'd30, 8'd40);
        issue(3'd0, 8'd250, 8'd60);
      end
      begin
        @(negedge clk);
        snap = {bus.out_valid, bus.out, bus.flag_zero, bus.flag_carry, bus.flag_ovf};
        check("bp_first_valid", bus.out_valid, 1);
        repeat (3) begin
          @(negedge clk);
          check("bp_hold", {bus.out_valid, bus.out, bus.flag_zero, bus.flag_carry, bus.flag_ovf}, snap);
          check("bp_in_ready", bus.in_ready, 0);
        end
        sync();
        bus.out_ready = 1'b1;
        repeat (3) begin
          @(negedge clk);
          check("bp_drain_valid", bus.out_valid, 1);
        end
      end
    join
    sync();

    // randomized ops with random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 80; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = W'($urandom);
      rb  = (rop >= 3'd5 && $urandom_range(0, 1) == 1) ? W'($urandom_range(0, W + 1)) : W'($urandom);
      issue(rop, ra, rb);
      if ($urandom_range(0, 3) == 0) sync();
    end
    rand_bp = 1'b0;
    sync();
    bus.out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
    sync();

    // asynchronous reset with work in flight
`ifdef ALU_MUL_EN
    issue(3'd0, 8'd7, 8'd9);
    issue(3'd7, 8'd200, 8'd3);
    repeat (3) @(posedge clk);
    #2;
    nreset = 1'b0;
    #1;
    check_reset_outputs("reset_mid_mul");
`else
    bus.out_ready = 1'b0;
    issue(3'd0, 8'd7, 8'd9);
    @(posedge clk);
    #2;
    nreset = 1'b0;
    #1;
    check_reset_outputs("reset_held_result");
`endif
    exp_q.delete();
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nreset = 1'b1;
    repeat (W + 2) @(negedge clk);
    check("post_reset_no_result", bus.out_valid, 0);
    sync();
    issue(3'd0, 8'd1, 8'd1);
    wait_valid("post_reset_add", 1);
    sync();
    check("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
